// File: rtl/led_ring_ctrl_if.sv
// Signal bundle between the rotary/button front end and the LED ring controller.
interface led_ring_ctrl_if;
  logic       rot_event;
  logic       rot_dir;
  logic       btn_mode;
  logic       step_out;
  logic       step_dir;
  logic [1:0] mode;
  logic [3:0] pending;

  // Controller side: consumes encoder/button levels, produces step commands.
  modport slave (
    input  rot_event,
    input  rot_dir,
    input  btn_mode,
    output step_out,
    output step_dir,
    output mode,
    output pending
  );

  // Stimulus side: drives encoder/button levels, observes step commands.
  modport master (
    output rot_event,
    output rot_dir,
    output btn_mode,
    input  step_out,
    input  step_dir,
    input  mode,
    input  pending
  );
endinterface

// File: rtl/led_ring_ctrl.sv
// LED ring controller: queues encoder steps (MANUAL), free-runs (AUTO) or
// holds (PAUSE), releasing at most one step command per tick period.
module led_ring_ctrl #(
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned MAX_PEND = 7
) (
  input logic            clk,
  input logic            rst,
  led_ring_ctrl_if.slave bus
);

  localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_DIV - 1);
  localparam logic signed [4:0] PendMax = 5'(MAX_PEND);
  localparam logic signed [4:0] PendMin = -PendMax;

  typedef enum logic [1:0] {
    StManual  = 2'b00,
    StAuto    = 2'b01,
    StPause   = 2'b10,
    StIllegal = 2'b11
  } mode_e;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               tick;
  logic               prev_rot_q, prev_btn_q;
  logic               rot_rise, btn_rise;
  mode_e              mode_q, mode_d;
  logic signed [3:0]  pend_q, pend_d;
  logic signed [4:0]  pend_sum;
  logic               auto_dir_q, auto_dir_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;

  // Edge detectors; prev registers reset high so levels held across reset give no edge.
  assign rot_rise = bus.rot_event & ~prev_rot_q;
  assign btn_rise = bus.btn_mode & ~prev_btn_q;

  // Free-running tick divider, independent of mode.
  assign tick  = (cnt_q == CntMax);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Next-state for mode, queue, auto direction and the step command.
  always_comb begin
    mode_d     = mode_q;
    pend_d     = pend_q;
    auto_dir_d = auto_dir_q;
    step_d     = 1'b0;
    dir_d      = 1'b0;
    pend_sum   = {pend_q[3], pend_q};
    case (mode_q)
      StManual: begin
        if (rot_rise) begin
          pend_sum = bus.rot_dir ? pend_sum + 5'sd1 : pend_sum - 5'sd1;
        end
        if (tick && (pend_q != 4'sd0)) begin
          step_d   = 1'b1;
          dir_d    = ~pend_q[3];
          // Step drains the queue one toward zero, combined with any new event.
          pend_sum = pend_q[3] ? pend_sum + 5'sd1 : pend_sum - 5'sd1;
        end
        if (pend_sum > PendMax) begin
          pend_sum = PendMax;
        end else if (pend_sum < PendMin) begin
          pend_sum = PendMin;
        end
        pend_d = pend_sum[3:0];
        if (btn_rise) begin
          mode_d = StAuto;
          pend_d = 4'sd0;
        end
      end
      StAuto: begin
        pend_d = 4'sd0;
        if (tick) begin
          step_d = 1'b1;
          dir_d  = auto_dir_q;
        end
        if (rot_rise) begin
          auto_dir_d = bus.rot_dir;
        end
        if (btn_rise) begin
          mode_d = StPause;
        end
      end
      StPause: begin
        if (btn_rise) begin
          mode_d = StManual;
        end
      end
      default: begin
        mode_d = StManual;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      prev_rot_q <= 1'b1;
      prev_btn_q <= 1'b1;
      mode_q     <= StManual;
      pend_q     <= 4'sd0;
      auto_dir_q <= 1'b1;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prev_rot_q <= bus.rot_event;
      prev_btn_q <= bus.btn_mode;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      auto_dir_q <= auto_dir_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
    end
  end

  assign bus.step_out = step_q;
  assign bus.step_dir = dir_q;
  assign bus.mode     = mode_q;
  assign bus.pending  = pend_q;

endmodule

// File: tb/tb_led_ring_ctrl.sv
// Self-checking bench for led_ring_ctrl against a cycle-level behavioural model.
module tb_led_ring_ctrl;

  localparam int StepDiv = 4;
  localparam int MaxPend = 7;

  logic clk;
  logic rst;
  led_ring_ctrl_if bus ();

  led_ring_ctrl #(
    .STEP_DIV (StepDiv),
    .MAX_PEND (MaxPend)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model state: mode 0 MANUAL, 1 AUTO, 2 PAUSE; edges counted since reset release.
  int m_mode;
  int m_pend;
  int m_adir;
  int m_edges;
  int m_prev_rot;
  int m_prev_btn;
  int exp_step;
  int exp_dir;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_pend     = 0;
    m_adir     = 1;
    m_edges    = 0;
    m_prev_rot = 1;
    m_prev_btn = 1;
    exp_step   = 0;
    exp_dir    = 0;
  endtask

  // One rising edge of behaviour, computed from the rules rather than registers.
  task automatic model_edge(input int r, input int d, input int b);
    int tick;
    int rot_rise;
    int btn_rise;
    int np;
    tick     = ((m_edges % StepDiv) == StepDiv - 1) ? 1 : 0;
    rot_rise = (r == 1 && m_prev_rot == 0) ? 1 : 0;
    btn_rise = (b == 1 && m_prev_btn == 0) ? 1 : 0;
    m_edges++;
    m_prev_rot = r;
    m_prev_btn = b;
    exp_step = 0;
    exp_dir  = 0;
    if (m_mode == 0) begin
      np = m_pend;
      if (rot_rise == 1) np += (d == 1) ? 1 : -1;
      if (tick == 1 && m_pend != 0) begin
        exp_step = 1;
        exp_dir  = (m_pend > 0) ? 1 : 0;
        np += (m_pend > 0) ? -1 : 1;
      end
      if (np > MaxPend) np = MaxPend;
      if (np < -MaxPend) np = -MaxPend;
      m_pend = np;
    end else if (m_mode == 1) begin
      if (tick == 1) begin
        exp_step = 1;
        exp_dir  = m_adir;
      end
      if (rot_rise == 1) m_adir = d;
      m_pend = 0;
    end
    if (btn_rise == 1) begin
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) m_pend = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("step_out", int'(bus.step_out), exp_step);
    if (exp_step == 1) check_val("step_dir", int'(bus.step_dir), exp_dir);
    check_val("mode", int'(bus.mode), m_mode);
    check_val("pending", int'($signed(bus.pending)), m_pend);
  endtask

  task automatic drive(input logic r, input logic d, input logic b);
    @(negedge clk);
    bus.rot_event = r;
    bus.rot_dir   = d;
    bus.btn_mode  = b;
    @(posedge clk);
    model_edge(int'(r), int'(d), int'(b));
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, bus.rot_dir, 1'b0);
  endtask

  task automatic rises(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, d, 1'b0);
      drive(1'b0, d, 1'b0);
    end
  endtask

  task automatic press();
    drive(1'b0, bus.rot_dir, 1'b1);
    drive(1'b0, bus.rot_dir, 1'b0);
  endtask

  // Mid-cycle asynchronous reset; inputs r/d/b are held across the release edge.
  task automatic async_reset(input logic r, input logic d, input logic b);
    @(negedge clk);
    #2;
    bus.rot_event = r;
    bus.rot_dir   = d;
    bus.btn_mode  = b;
    rst = 1'b1;
    #1;
    check_val("rst_step_out", int'(bus.step_out), 0);
    check_val("rst_step_dir", int'(bus.step_dir), 0);
    check_val("rst_mode", int'(bus.mode), 0);
    check_val("rst_pending", int'(bus.pending), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_edge(int'(r), int'(d), int'(b));
    #1;
    check_outputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.rot_event = 1'b1;
    bus.rot_dir   = 1'b1;
    bus.btn_mode  = 1'b1;
    model_reset();
    #1;
    check_val("init_mode", int'(bus.mode), 0);
    check_val("init_pending", int'(bus.pending), 0);
    check_val("init_step_out", int'(bus.step_out), 0);

    // Inputs high across release must not register as edges.
    async_reset(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);

    // Queue up three steps, drain them, expect no extra pulse.
    async_reset(1'b0, 1'b1, 1'b0);
    rises(3, 1'b1);
    idle(20);

    // Burst of down events drives the queue into negative saturation.
    rises(40, 1'b0);
    idle(40);

    // Build positive queue, enter AUTO, then flip direction.
    rises(6, 1'b1);
    press();
    idle(12);
    rises(1, 1'b0);
    idle(12);

    // PAUSE ignores rotation, then back to MANUAL.
    press();
    rises(4, 1'b1);
    idle(10);
    press();
    idle(4);

    // Reset with work queued.
    rises(8, 1'b1);
    async_reset(1'b0, 1'b0, 1'b0);
    idle(6);

    // Randomized operation with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_ring_ctrl.md
LED_RING_CTRL -- requirements
Module: led_ring_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4, meaning clock cycles per step tick (range 2..2^24).
REQ-002 SHALL have parameter MAX_PEND, default 7, meaning the pending-step saturation magnitude (range 1..7).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the single system clock (all logic on posedge).
REQ-005 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-006 SHALL have port rot_event, input, 1, the rotary-encoder event level (already synchronous to clk).
REQ-007 SHALL have port rot_dir, input, 1, the rotation direction (1 = up/left, 0 = down/right), sampled on the rot_event rising edge.
REQ-008 SHALL have port btn_mode, input, 1, the mode button level (already debounced and synchronous).
REQ-009 SHALL have port step_out, output, 1, a one-cycle step command to the LED shifter.
REQ-010 SHALL have port step_dir, output, 1, the direction of the step_out pulse; it is valid only while step_out=1.
REQ-011 SHALL have port mode, output, 2, the current state: 00 MANUAL, 01 AUTO, 10 PAUSE.
REQ-012 SHALL have port pending, output, 4, the signed two's-complement count of queued steps.

Function
REQ-013 SHALL detect the rot_event rise as prev=0 and current=1, with the prev register reset to 1; btn_mode rise SHALL be detected identically.
REQ-014 SHALL run the tick counter as 0..STEP_DIV-1 and wrap; tick SHALL be asserted when counter=STEP_DIV-1, in every mode.
REQ-015 SHALL drive step_out and step_dir as registered outputs, set at the clock edge where tick=1 and the step condition holds; step_out SHALL otherwise be 0.
REQ-016 In MANUAL, a rot rise SHALL add +1 to pending when rot_dir=1 and -1 when rot_dir=0.
REQ-017 In MANUAL on tick with pending!=0, the block SHALL emit a step with step_dir=1 if pending>0 and 0 if pending<0, and SHALL move pending one toward 0.
REQ-018 When a rot rise and a step coincide, both deltas SHALL be applied in the same cycle; the result SHALL saturate to [-MAX_PEND, +MAX_PEND], and excess events SHALL be dropped.
REQ-019 In AUTO, every tick SHALL emit a step with step_dir=auto_dir; a rot rise SHALL set auto_dir to rot_dir; pending SHALL be held at 0.
REQ-020 In PAUSE, the block SHALL emit no steps, ignore rot rises, and retain pending and auto_dir.
REQ-021 A btn_mode rise SHALL advance the FSM MANUAL->AUTO->PAUSE->MANUAL; mode code 11 SHALL be unreachable and, if entered, SHALL go to MANUAL next cycle.
REQ-022 Entering AUTO SHALL clear pending to 0.
REQ-023 Entering MANUAL from PAUSE SHALL keep pending at 0.
REQ-024 The step decision and rot handling on any cycle SHALL use the registered (current) mode, not the next mode.
REQ-025 The tick counter SHALL NOT reset on mode changes.

Reset
REQ-026 While rst=1, the block SHALL drive: step_out=0, step_dir=0, mode=00, pending=0, auto_dir=1, counter=0, prev registers=1.
REQ-027 Reset asserted mid-operation SHALL take effect immediately (asynchronously) and discard queued steps.
REQ-028 After rst falls, the first tick SHALL occur at the STEP_DIV-th rising edge.
REQ-029 Inputs held high across reset release SHALL NOT produce an edge.

Verification
REQ-030 Reset release; 3 rot rises with rot_dir=1 before the first tick -> pending=3, then step_out pulses on ticks 1,2,3 with step_dir=1; pending reaches 0; no 4th pulse.
REQ-031 10 rot rises with rot_dir=0 inside one tick period -> pending saturates at -7 (4'b1001); exactly 7 pulses follow, each with step_dir=0.
REQ-032 Rot rise with rot_dir=1 on the same cycle pending=+2 emits a step -> pending=+2 afterwards (+1 and -1 applied together).
REQ-033 btn_mode rise with pending=+4 -> mode=01, pending=0; a pulse every 4 cycles with step_dir=1; rot rise with rot_dir=0 -> subsequent pulses have step_dir=0.
REQ-034 Two further btn_mode rises -> mode=10 with no pulses and rot rises ignored, then mode=00 with pending=0; rst asserted with pending=+5 -> all outputs 0 within the same cycle.
